freq_meas_sequencer: RTL

Measurement controller for the GoBoard frequency display. It sequences one gated edge-count of an external clock pin: clear, open a gate of range-dependent length, latch the result. It handles range selection from a switch and a hold request. It drives the two-digit value into the 7-segment encoders and a one-hot range indication to the LEDs.

---
 rtl/freq_seq_pkg.sv | 50 +++++
 rtl/sync_edge_det.sv | 38 +++
 rtl/freq_meas_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/freq_seq_pkg.sv
// ---------------------------------------------------------------------------
// freq_seq_pkg
// Shared definitions for the frequency-measurement sequencer:
//   - sequencer state encoding (CLEAR, GATE, LATCH, HOLD)
//   - measurement range encoding, its one-hot LED constants and step order
//   - edge-count saturation value and the largest displayable count
// ---------------------------------------------------------------------------
package freq_seq_pkg;

    // Sequencer states
    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_GATE  = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // Measurement ranges
    typedef enum logic [1:0] {
        RANGE_HZ  = 2'd0,
        RANGE_KHZ = 2'd1,
        RANGE_MHZ = 2'd2
    } range_e;

    localparam logic [2:0] ONEHOT_HZ  = 3'b001;
    localparam logic [2:0] ONEHOT_KHZ = 3'b010;
    localparam logic [2:0] ONEHOT_MHZ = 3'b100;

    // The edge counter stops here so it never wraps back into the
    // displayable range on a fast input.
    localparam logic [6:0] EDGE_SAT = 7'd100;
    // Largest count that fits on two decimal digits.
    localparam logic [6:0] DISP_MAX = 7'd99;

    function automatic logic [2:0] range_onehot(input range_e r);
        case (r)
            RANGE_KHZ: range_onehot = ONEHOT_KHZ;
            RANGE_MHZ: range_onehot = ONEHOT_MHZ;
            default:   range_onehot = ONEHOT_HZ;
        endcase
    endfunction

    // Hz -> kHz -> MHz -> Hz
    function automatic range_e range_next(input range_e r);
        case (r)
            RANGE_HZ:  range_next = RANGE_KHZ;
            RANGE_KHZ: range_next = RANGE_MHZ;
            default:   range_next = RANGE_HZ;
        endcase
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer followed by a registered rising-edge detector.
// Produces a one-cycle pulse for every rising edge of the asynchronous
// input. All flops clear on synchronous reset.
//
// Ports:
//   i_Clk    - system clock
//   i_Reset  - synchronous, active-high reset
//   i_Async  - asynchronous level to be synchronized
//   o_Pulse  - one-cycle pulse per rising edge of i_Async
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_Async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_Pulse = r_sync & ~r_prev;

endmodule

// File: rtl/freq_meas_sequencer.sv
// ---------------------------------------------------------------------------
// freq_meas_sequencer
// Sequences one gated edge count of an external clock pin at a time:
// CLEAR the counters, open a gate whose length depends on the selected
// range, LATCH the result onto the display outputs, optionally HOLD.
// A rising edge on the range switch steps Hz -> kHz -> MHz -> Hz and
// restarts the measurement.
//
// Build option:
//   FREQ_SEQ_BCD_EN defined     : o_Display_Value is packed BCD (47 -> 0x47)
//   FREQ_SEQ_BCD_EN not defined : o_Display_Value is the binary count (47 -> 0x2F)
//
// Handshake: o_Valid is a one-cycle pulse with no ready; o_Display_Value
// and o_Overflow change only in the cycle o_Valid is high (or at reset) and
// stay stable until the next pulse.
//
// Parameters:
//   GATE_HZ / GATE_KHZ / GATE_MHZ - gate length in i_Clk cycles per range
//   GATE_W                        - gate counter width, must hold GATE_HZ
// Ports:
//   i_Clk           - 25 MHz system clock
//   i_Reset         - synchronous, active-high reset
//   i_Ext_Clk       - asynchronous measured signal
//   i_Range_Step    - debounced switch level, rising edge steps the range
//   i_Hold          - freeze the display after the next latch while high
//   o_Display_Value - [7:4] tens digit, [3:0] units digit
//   o_Range         - one-hot range: 001 Hz, 010 kHz, 100 MHz
//   o_Overflow      - last latched count was >= 100
//   o_Valid         - one-cycle pulse when a new result is latched
//   o_Busy          - high while the gate is open
// ---------------------------------------------------------------------------
module freq_meas_sequencer
    import freq_seq_pkg::*;
#(
    parameter int GATE_HZ  = 25_000_000,
    parameter int GATE_KHZ = 25_000,
    parameter int GATE_MHZ = 25,
    parameter int GATE_W   = 25
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Ext_Clk,
    input  logic       i_Range_Step,
    input  logic       i_Hold,
    output logic [7:0] o_Display_Value,
    output logic [2:0] o_Range,
    output logic       o_Overflow,
    output logic       o_Valid,
    output logic       o_Busy
);

    localparam logic [GATE_W-1:0] LEN_HZ    = GATE_W'(GATE_HZ);
    localparam logic [GATE_W-1:0] LEN_KHZ   = GATE_W'(GATE_KHZ);
    localparam logic [GATE_W-1:0] LEN_MHZ   = GATE_W'(GATE_MHZ);
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);

    // -----------------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------------
    logic w_ext_pulse;
    logic w_step_pulse;

    sync_edge_det u_ext_edge (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Async (i_Ext_Clk),
        .o_Pulse (w_ext_pulse)
    );

    // The switch is already synchronous after debouncing; reusing the same
    // block keeps the logic uniform and costs two extra cycles of latency.
    sync_edge_det u_step_edge (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Async (i_Range_Step),
        .o_Pulse (w_step_pulse)
    );

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    range_e            r_range;
    logic [6:0]        r_edge_cnt;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [7:0]        r_display;
    logic              r_overflow;
    logic              r_valid;

    logic [GATE_W-1:0] w_gate_len;
    logic [GATE_W-1:0] w_gate_term;
    logic              w_gate_done;
    logic [7:0]        w_disp_next;

    always_comb begin
        w_gate_len = LEN_HZ;
        case (r_range)
            RANGE_KHZ: w_gate_len = LEN_KHZ;
            RANGE_MHZ: w_gate_len = LEN_MHZ;
            default:   w_gate_len = LEN_HZ;
        endcase
    end

    assign w_gate_term = w_gate_len - GATE_ONE;
    assign w_gate_done = (r_state == ST_GATE) && (r_gate_cnt == w_gate_term);

    // -----------------------------------------------------------------------
    // Display value formatting
    // -----------------------------------------------------------------------
`ifdef FREQ_SEQ_BCD_EN
    logic [3:0] w_tens;
    logic [3:0] w_units;

    // Divide-by-10 for 0..99 as a comparator ladder: the highest multiple
    // of ten not exceeding the count gives the tens digit.
    always_comb begin
        w_tens = 4'd0;
        for (int k = 1; k <= 9; k++) begin
            if (r_edge_cnt >= 7'(k * 10)) begin
                w_tens = 4'(k);
            end
        end
        w_units = 4'(r_edge_cnt - 7'(w_tens * 4'd10));
    end

    always_comb begin
        w_disp_next = {w_tens, w_units};
        if (r_edge_cnt > DISP_MAX) begin
            w_disp_next = 8'h00;
        end
    end
`else
    always_comb begin
        w_disp_next = {1'b0, r_edge_cnt};
        if (r_edge_cnt > DISP_MAX) begin
            w_disp_next = 8'h00;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state logic. A range step overrides every other transition,
    // including a gate terminal count in the same cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_step_pulse) begin
            w_state_next = ST_CLEAR;
        end else begin
            case (r_state)
                ST_CLEAR: w_state_next = ST_GATE;
                ST_GATE:  w_state_next = w_gate_done ? ST_LATCH : ST_GATE;
                ST_LATCH: w_state_next = i_Hold ? ST_HOLD : ST_CLEAR;
                ST_HOLD:  w_state_next = i_Hold ? ST_HOLD : ST_CLEAR;
                default:  w_state_next = ST_CLEAR;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= ST_CLEAR;
            r_range    <= RANGE_HZ;
            r_edge_cnt <= 7'd0;
            r_gate_cnt <= '0;
            r_display  <= 8'h00;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_step_pulse) begin
                r_range <= range_next(r_range);
            end

            // Counters: cleared on CLEAR or an aborting step, run only in GATE.
            if (w_step_pulse || (r_state == ST_CLEAR)) begin
                r_edge_cnt <= 7'd0;
                r_gate_cnt <= '0;
            end else if (r_state == ST_GATE) begin
                if (w_ext_pulse && (r_edge_cnt < EDGE_SAT)) begin
                    r_edge_cnt <= r_edge_cnt + 7'd1;
                end
                if (!w_gate_done) begin
                    r_gate_cnt <= r_gate_cnt + GATE_ONE;
                end
            end

            // Result latch. A step arriving in LATCH discards the result so
            // the display never shows a count taken under the old range.
            r_valid <= 1'b0;
            if (!w_step_pulse && (r_state == ST_LATCH)) begin
                r_display  <= w_disp_next;
                r_overflow <= (r_edge_cnt > DISP_MAX);
                r_valid    <= 1'b1;
            end
        end
    end

    assign o_Display_Value = r_display;
    assign o_Overflow      = r_overflow;
    assign o_Valid         = r_valid;
    assign o_Range         = range_onehot(r_range);
    assign o_Busy          = (r_state == ST_GATE);

endmodule
